// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART sender between the boot loader and the CPU.
// Boot bytes preempt the CPU FIFO, which drains only once the program is loaded.
module uart_tx_arbiter #(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [7:0]             o_sdata,
    input  logic                   i_boot_start,
    input  logic [7:0]             i_boot_data,
    output logic                   o_boot_busy,
    input  logic                   i_program_loaded,
    input  logic                   i_cpu_valid,
    input  logic [7:0]             i_cpu_data,
    output logic                   o_cpu_ready,
    output logic [$clog2(DEPTH):0] o_fifo_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        HOLD,
        DRAIN
    } state_t;

    state_t        r_state;
    logic          r_tx_start;
    logic [7:0]    r_sdata;
    logic          r_pend;
    logic [7:0]    r_pbyte;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_wr;
    logic w_pop;
    logic w_boot_go;

    assign w_boot_go = (r_state == IDLE) && !i_tx_busy && r_pend;
    assign w_pop     = (r_state == IDLE) && !i_tx_busy && !r_pend
                       && i_program_loaded && (r_count != '0);

    // count never exceeds DEPTH (a power of two), so its MSB means full
    assign o_cpu_ready  = ~r_count[AW];
    assign w_wr         = i_cpu_valid & o_cpu_ready;
    assign o_fifo_count = r_count;
    assign o_boot_busy  = r_pend | (r_state != IDLE) | i_tx_busy;
    assign o_tx_start   = r_tx_start;
    assign o_sdata      = r_sdata;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_cpu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_sdata    <= '0;
            r_pend     <= 1'b0;
            r_pbyte    <= '0;
        end else begin
            if (i_boot_start && !r_pend) begin
                r_pend  <= 1'b1;
                r_pbyte <= i_boot_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_boot_go) begin
                        r_pend     <= 1'b0;
                        r_sdata    <= r_pbyte;
                        r_tx_start <= 1'b1;
                        r_state    <= START;
                    end else if (w_pop) begin
                        r_sdata    <= r_mem[r_rptr];
                        r_tx_start <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= HOLD;
                end
                // sender asserts busy one cycle late, so skip its value here
                HOLD: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!i_tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table for cycle timing plus sequences
// driven by a sender model for FIFO wrap, double boot and mid-send reset.
module tb_uart_tx_arbiter;
    localparam int DEPTH  = 16;
    localparam int BUSY_N = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] sdata;
    logic       boot_start = 1'b0;
    logic [7:0] boot_data = 8'h00;
    logic       boot_busy;
    logic       program_loaded = 1'b0;
    logic       cpu_valid = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_ready;
    logic [4:0] fifo_count;

    logic       use_model = 1'b0;
    logic       vbusy = 1'b0;
    int         bcnt = 0;
    logic [7:0] sent [$];
    int         checks = 0;
    int         failures = 0;

    uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .i_tx_busy       (tx_busy),
        .o_tx_start      (tx_start),
        .o_sdata         (sdata),
        .i_boot_start    (boot_start),
        .i_boot_data     (boot_data),
        .o_boot_busy     (boot_busy),
        .i_program_loaded(program_loaded),
        .i_cpu_valid     (cpu_valid),
        .i_cpu_data      (cpu_data),
        .o_cpu_ready     (cpu_ready),
        .o_fifo_count    (fifo_count)
    );

    always #5 clock = ~clock;

    assign tx_busy = use_model ? (bcnt != 0) : vbusy;

    // Sender model: samples tx_start at the edge, busy from the next cycle.
    always @(posedge clock) begin
        if (tx_start) begin
            bcnt <= BUSY_N;
            sent.push_back(sdata);
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    typedef struct {
        logic       bs;
        logic [7:0] bd;
        logic       ld;
        logic       cv;
        logic [7:0] cd;
        logic       busy;
        logic       e_st;
        logic [7:0] e_sd;
        logic       e_bb;
        logic       e_rdy;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t vt [26];

    function automatic vec_t mk(logic bs, logic [7:0] bd, logic ld,
                                logic cv, logic [7:0] cd, logic busy,
                                logic st, logic [7:0] sd, logic bb,
                                logic rdy, logic [4:0] cnt);
        vec_t v;
        v.bs = bs; v.bd = bd; v.ld = ld; v.cv = cv; v.cd = cd;
        v.busy = busy; v.e_st = st; v.e_sd = sd; v.e_bb = bb;
        v.e_rdy = rdy; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (boot_busy && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (boot_busy) begin
            failures++;
            $display("FAIL %s timeout actual=busy expected=idle", name);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [4:0] cnt0;

        vt[0]  = mk(1, 8'h99, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0);
        vt[1]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h99, 1, 1, 0);
        vt[2]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h99, 1, 1, 0);
        vt[3]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h99, 1, 1, 0);
        vt[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h99, 0, 1, 0);
        vt[5]  = mk(0, 8'h00, 0, 1, 8'h41, 0, 0, 8'h99, 0, 1, 1);
        vt[6]  = mk(0, 8'h00, 0, 1, 8'h42, 0, 0, 8'h99, 0, 1, 2);
        vt[7]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h41, 1, 1, 1);
        vt[8]  = mk(1, 8'haa, 1, 0, 8'h00, 1, 0, 8'h41, 1, 1, 1);
        vt[9]  = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h41, 1, 1, 1);
        vt[10] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h41, 1, 1, 1);
        vt[11] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h41, 1, 1, 1);
        vt[12] = mk(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'haa, 1, 1, 1);
        vt[13] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'haa, 1, 1, 1);
        vt[14] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'haa, 1, 1, 1);
        vt[15] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'haa, 0, 1, 1);
        vt[16] = mk(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h42, 1, 1, 0);
        vt[17] = mk(0, 8'h00, 1, 1, 8'h43, 1, 0, 8'h42, 1, 1, 1);
        vt[18] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h42, 1, 1, 1);
        vt[19] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h42, 0, 1, 1);
        vt[20] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h42, 0, 1, 1);
        vt[21] = mk(0, 8'h00, 1, 1, 8'h44, 0, 1, 8'h43, 1, 1, 1);
        vt[22] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h43, 1, 1, 1);
        vt[23] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h43, 1, 1, 1);
        vt[24] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h43, 0, 1, 1);
        vt[25] = mk(0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h44, 1, 1, 0);

        step();
        step();
        reset = 1'b0;
        chk("reset_state", {tx_start, sdata, boot_busy, cpu_ready, fifo_count},
            {1'b0, 8'h00, 1'b0, 1'b1, 5'd0});

        for (int i = 0; i < 26; i++) begin
            boot_start     = vt[i].bs;
            boot_data      = vt[i].bd;
            program_loaded = vt[i].ld;
            cpu_valid      = vt[i].cv;
            cpu_data       = vt[i].cd;
            vbusy          = vt[i].busy;
            step();
            chk($sformatf("vec%0d", i),
                {tx_start, sdata, boot_busy, cpu_ready, fifo_count},
                {vt[i].e_st, vt[i].e_sd, vt[i].e_bb, vt[i].e_rdy, vt[i].e_cnt});
        end
        boot_start = 1'b0;
        cpu_valid = 1'b0;
        program_loaded = 1'b0;
        use_model = 1'b1;

        // Fill to full, drop a stray write, then drain across the wrap.
        pulse_reset();
        wait_idle("idle_before_fill");
        sent.delete();
        for (int i = 0; i < DEPTH; i++) begin
            cpu_valid = 1'b1;
            cpu_data = 8'h60 + 8'(i);
            step();
        end
        cpu_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ready", 32'(cpu_ready), 32'd0);
        cpu_valid = 1'b1;
        cpu_data = 8'hee;
        step();
        cpu_valid = 1'b0;
        chk("full_drop", 32'(fifo_count), 32'd16);
        program_loaded = 1'b1;
        step();
        chk("first_pop", {tx_start, sdata, fifo_count}, {1'b1, 8'h60, 5'd15});
        step();
        wait_idle("wait_pop_slot");
        cnt0 = fifo_count;
        cpu_valid = 1'b1;
        cpu_data = 8'h70;
        step();
        cpu_valid = 1'b0;
        chk("wr_pop_count", 32'(fifo_count), 32'(cnt0));
        chk("wr_pop_start", 32'(tx_start), 32'd1);
        n = 0;
        while (sent.size() < 17 && n < 1000) begin
            step();
            n++;
        end
        chk("wrap_size", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 17 && i < sent.size(); i++) begin
            chk($sformatf("wrap_byte%0d", i), 32'(sent[i]),
                (i < 16) ? 32'(8'h60 + 8'(i)) : 32'h70);
        end
        wait_idle("idle_after_wrap");
        chk("wrap_empty", 32'(fifo_count), 32'd0);

        // Back-to-back boot pulses: second is ignored while pending.
        program_loaded = 1'b0;
        pulse_reset();
        wait_idle("idle_before_dbl");
        sent.delete();
        boot_start = 1'b1;
        boot_data = 8'h11;
        step();
        boot_data = 8'h22;
        step();
        boot_start = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("dbl_size", 32'(sent.size()), 32'd1);
        if (sent.size() > 0) chk("dbl_byte", 32'(sent[0]), 32'h11);

        // Reset during DRAIN with 5 queued and a boot byte pending.
        wait_idle("idle_before_rst");
        sent.delete();
        for (int i = 0; i < 5; i++) begin
            cpu_valid = 1'b1;
            cpu_data = 8'h80 + 8'(i);
            step();
        end
        cpu_valid = 1'b0;
        boot_start = 1'b1;
        boot_data = 8'h33;
        step();
        boot_start = 1'b0;
        step();
        chk("rst_launch", {tx_start, sdata}, {1'b1, 8'h33});
        step();
        step();
        boot_start = 1'b1;
        boot_data = 8'h44;
        step();
        boot_start = 1'b0;
        chk("rst_pre_count", 32'(fifo_count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_post", {tx_start, cpu_ready, fifo_count}, {1'b0, 1'b1, 5'd0});
        program_loaded = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("rst_no_launch", 32'(sent.size()), 32'd1);
        chk("rst_pend_clear", 32'(boot_busy), 32'd0);
        boot_start = 1'b1;
        boot_data = 8'h55;
        step();
        boot_start = 1'b0;
        step();
        chk("rst_new_req", {tx_start, sdata}, {1'b1, 8'h55});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
